stopwatch_bcd_counter: RTL and testbench
========================================

// Module: stopwatch_bcd_counter
// PURPOSE
//  Stopwatch time base feeding the 4-digit display multiplexer. Counts SS.hh
//  (seconds, hundredths) in BCD from the 1 ms system clock. Debounces start/stop
//  and clear buttons. Presents four registered BCD digits, leftmost first.
// PARAMETERS
//  TICK_DIV  10  clk cycles per hundredth (1 ms clk -> 10 ms)
//  DB_MS     20  consecutive stable clk cycles needed to accept a button level
// PORTS
//  clk             in   1  system clock, 1 ms period
//  sys_rst_n       in   1  async active-low reset
//  btn_start_stop  in   1  raw button, active-high, asynchronous, bouncy
//  btn_clear       in   1  raw button, active-high, asynchronous, bouncy
//  btn_lap         in   1  raw button, active-high; used only with STOPWATCH_LAP_EN
//  dig0            out  4  seconds tens, 0..5 (display position 0)
//  dig1            out  4  seconds units, 0..9
//  dig2            out  4  tenths, 0..9
//  dig3            out  4  hundredths, 0..9
//  running         out  1  high while in RUN
//  wrap            out  1  one-cycle pulse on the 59.99 -> 00.00 rollover
//  lap_held        out  1  display frozen by lap (0 when the feature is absent)
// BEHAVIOUR
//  Reset: all digits 0, running 0, wrap 0, lap_held 0, state IDLE,
//   prescaler 0, synchronisers and debounced levels 0.
//  Debounce, per button:
//   - 2-FF synchroniser, then a counter. The counter clears when the synced
//     input differs from the debounced level.
//   - After DB_MS equal-differing cycles, the debounced level flips.
//   - A 0->1 flip emits a 1-cycle pulse, DB_MS+2 clks after a clean raw edge.
//   - Any glitch shorter than DB_MS produces no pulse.
//  FSM (acts on pulses):
//   - IDLE: ss_pulse -> RUN.
//   - RUN:  ss_pulse -> PAUSE. clr_pulse ignored.
//   - PAUSE: ss_pulse -> RUN. clr_pulse -> IDLE.
//   - Same-cycle ss+clr in PAUSE: clear wins (-> IDLE). In IDLE or RUN, ss acts.
//  Prescaler:
//   - Counts 0..TICK_DIV-1 only in RUN; holds in PAUSE; forced 0 in IDLE.
//   - tick = (prescaler == TICK_DIV-1) in RUN.
//   - First tick is TICK_DIV clks after entering RUN.
//  BCD cascade on tick: dig3++. Each digit carries at 9, except dig0 at 5.
//   - Digits update on the same edge as the tick; no further latency.
//   - 59.99 + tick -> 00.00, wrap=1 for that cycle, stays RUN.
//   - Digits never hold a non-BCD value.
//  Entering IDLE zeroes all digits on the same edge. running = (state==RUN), registered.
// CONFIGURATION
//  STOPWATCH_LAP_EN defined:
//   - btn_lap is debounced like the other buttons.
//   - A lap pulse in RUN toggles hold. While held, dig0..3 show the value
//     captured at the pulse; the internal count continues.
//   - Lap pulses in IDLE/PAUSE are ignored. PAUSE keeps the hold.
//   - Entering IDLE releases the hold.
//   - lap_held mirrors the hold.
//  Undefined: btn_lap ignored, digits always live, lap_held tied 0.
// TESTING  (sim params TICK_DIV=10, DB_MS=4)
//  1. Reset mid-RUN at 00.37:
//     -> next edge: digits 00.00, running 0, IDLE.
//  2. Clean ss press from IDLE:
//     -> running=1 at raw edge+6; after 1000 further clks digits = 01.00.
//  3. ss toggled every 2 clks for 12 clks, then low:
//     -> no pulse, state stays IDLE, digits 00.00.
//  4. Run 60000 clks from 00.00:
//     -> 59.99 then 00.00 with wrap=1 exactly one cycle; running stays 1.
//  5. Pause at 00.37, clear, then ss+clear in the same cycle:
//     -> clear in RUN ignored; PAUSE+clear gives 00.00 IDLE; simultaneous gives IDLE.
//  6. (LAP_EN) lap at 00.50, run 200 clks:
//     -> digits stay 00.50, lap_held=1. Second lap -> digits 00.70, lap_held=0.

Source files
------------

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch SS.hh BCD time base with debounced start/stop, clear (and optional lap) buttons.
// Latency: button raw edge -> state change DB_MS+2 clks; tick -> digits same edge; outputs registered.
// Backpressure: none, free-running; optional lap hold enabled by defining STOPWATCH_LAP_EN.

module stopwatch_debounce #(
    parameter int DB_MS = 20
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_pulse
);
    localparam int CW = (DB_MS > 1) ? $clog2(DB_MS) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_done;

    assign w_diff  = r_sync2 ^ r_level;
    assign w_done  = w_diff && (r_cnt == CW'(DB_MS - 1));
    assign o_pulse = w_done && r_sync2;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            // counter measures how long the synced input has disagreed with the level
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end
endmodule

module stopwatch_bcd_counter #(
    parameter int TICK_DIV = 10,
    parameter int DB_MS    = 20
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       running,
    output logic       wrap,
    output logic       lap_held
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic          w_ss_pulse;
    logic          w_clr_pulse;
    logic [3:0]    r_d0, r_d1, r_d2, r_d3;
    logic [3:0]    w_d0_n, w_d1_n, w_d2_n, w_d3_n;
    logic          w_wrap_evt;
    logic          r_running;
    logic          r_wrap;

    stopwatch_debounce #(.DB_MS(DB_MS)) u_db_ss (
        .clk     (clk),
        .i_rst_n (sys_rst_n),
        .i_btn   (btn_start_stop),
        .o_pulse (w_ss_pulse)
    );

    stopwatch_debounce #(.DB_MS(DB_MS)) u_db_clr (
        .clk     (clk),
        .i_rst_n (sys_rst_n),
        .i_btn   (btn_clear),
        .o_pulse (w_clr_pulse)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_ss_pulse) w_state_nxt = S_RUN;
            S_RUN:   if (w_ss_pulse) w_state_nxt = S_PAUSE;
            S_PAUSE: begin
                // clear has priority over start when both land together
                if (w_clr_pulse)     w_state_nxt = S_IDLE;
                else if (w_ss_pulse) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == S_RUN);
        end
    end

    assign w_tick = (r_state == S_RUN) && (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_presc <= '0;
        end else if (w_state_nxt == S_IDLE) begin
            r_presc <= '0;
        end else if (r_state == S_RUN) begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
        end
    end

    always_comb begin
        w_d0_n     = r_d0;
        w_d1_n     = r_d1;
        w_d2_n     = r_d2;
        w_d3_n     = r_d3;
        w_wrap_evt = 1'b0;
        if (w_state_nxt == S_IDLE) begin
            w_d0_n = 4'd0;
            w_d1_n = 4'd0;
            w_d2_n = 4'd0;
            w_d3_n = 4'd0;
        end else if (w_tick) begin
            // carry on >= limit so a corrupted digit can never stick outside BCD
            if (r_d3 < 4'd9) begin
                w_d3_n = r_d3 + 4'd1;
            end else begin
                w_d3_n = 4'd0;
                if (r_d2 < 4'd9) begin
                    w_d2_n = r_d2 + 4'd1;
                end else begin
                    w_d2_n = 4'd0;
                    if (r_d1 < 4'd9) begin
                        w_d1_n = r_d1 + 4'd1;
                    end else begin
                        w_d1_n = 4'd0;
                        if (r_d0 < 4'd5) begin
                            w_d0_n = r_d0 + 4'd1;
                        end else begin
                            w_d0_n     = 4'd0;
                            w_wrap_evt = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_d0   <= 4'd0;
            r_d1   <= 4'd0;
            r_d2   <= 4'd0;
            r_d3   <= 4'd0;
            r_wrap <= 1'b0;
        end else begin
            r_d0   <= w_d0_n;
            r_d1   <= w_d1_n;
            r_d2   <= w_d2_n;
            r_d3   <= w_d3_n;
            r_wrap <= w_wrap_evt;
        end
    end

    assign running = r_running;
    assign wrap    = r_wrap;

`ifdef STOPWATCH_LAP_EN
    logic       w_lap_pulse;
    logic       w_lap_act;
    logic       w_capture;
    logic       w_hold_nxt;
    logic       r_hold;
    logic [3:0] r_c0, r_c1, r_c2, r_c3;
    logic [3:0] r_o0, r_o1, r_o2, r_o3;

    stopwatch_debounce #(.DB_MS(DB_MS)) u_db_lap (
        .clk     (clk),
        .i_rst_n (sys_rst_n),
        .i_btn   (btn_lap),
        .o_pulse (w_lap_pulse)
    );

    assign w_lap_act  = (r_state == S_RUN) && w_lap_pulse;
    assign w_capture  = w_lap_act && !r_hold;
    assign w_hold_nxt = (w_state_nxt == S_IDLE) ? 1'b0 : (r_hold ^ w_lap_act);

    // the captured value is what the live count shows after this edge
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_hold <= 1'b0;
            r_c0   <= 4'd0;
            r_c1   <= 4'd0;
            r_c2   <= 4'd0;
            r_c3   <= 4'd0;
            r_o0   <= 4'd0;
            r_o1   <= 4'd0;
            r_o2   <= 4'd0;
            r_o3   <= 4'd0;
        end else begin
            r_hold <= w_hold_nxt;
            if (w_capture) begin
                r_c0 <= w_d0_n;
                r_c1 <= w_d1_n;
                r_c2 <= w_d2_n;
                r_c3 <= w_d3_n;
            end
            if (w_hold_nxt && !w_capture) begin
                r_o0 <= r_c0;
                r_o1 <= r_c1;
                r_o2 <= r_c2;
                r_o3 <= r_c3;
            end else begin
                r_o0 <= w_d0_n;
                r_o1 <= w_d1_n;
                r_o2 <= w_d2_n;
                r_o3 <= w_d3_n;
            end
        end
    end

    assign dig0     = r_o0;
    assign dig1     = r_o1;
    assign dig2     = r_o2;
    assign dig3     = r_o3;
    assign lap_held = r_hold;
`else
    logic w_unused_lap;

    assign w_unused_lap = btn_lap;
    assign dig0         = r_d0;
    assign dig1         = r_d1;
    assign dig2         = r_d2;
    assign dig3         = r_d3;
    assign lap_held     = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Bench for stopwatch_bcd_counter: directed scenarios plus random button traffic,
// checked every cycle against a centisecond-count reference model.
module tb_stopwatch_bcd_counter;
    localparam int TD = 10;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       btn_start_stop = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_lap = 1'b0;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic       running, wrap, lap_held;

    stopwatch_bcd_counter #(.TICK_DIV(TD), .DB_MS(DB)) dut (
        .clk            (clk),
        .sys_rst_n      (sys_rst_n),
        .btn_start_stop (btn_start_stop),
        .btn_clear      (btn_clear),
        .btn_lap        (btn_lap),
        .dig0           (dig0),
        .dig1           (dig1),
        .dig2           (dig2),
        .dig3           (dig3),
        .running        (running),
        .wrap           (wrap),
        .lap_held       (lap_held)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: state 0=idle 1=run 2=pause, elapsed run clocks, lap hold
    int m_state;
    int m_run_clks;
    bit m_hold;
    int m_cap;
    bit m_wrap;
    bit hist[3][DB+1];
    bit lvl[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int live_cs();
        return (m_run_clks / TD) % 6000;
    endfunction

    // level accepted once the last DB samples (seen through a 2-flop delay) all disagree with it
    function automatic bit db(input int b, input bit raw);
        bit all_diff = 1'b1;
        bit rise;
        for (int i = 1; i <= DB; i++) if (hist[b][i] == lvl[b]) all_diff = 1'b0;
        rise = all_diff && !lvl[b];
        if (all_diff) lvl[b] = !lvl[b];
        for (int i = DB; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = raw;
        return rise;
    endfunction

    task automatic model_reset();
        m_state = 0; m_run_clks = 0; m_hold = 1'b0; m_cap = 0; m_wrap = 1'b0;
        for (int b = 0; b < 3; b++) begin
            lvl[b] = 1'b0;
            for (int i = 0; i <= DB; i++) hist[b][i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        bit ss, clr, lap;
        int nxt;
        ss  = db(0, btn_start_stop);
        clr = db(1, btn_clear);
        lap = db(2, btn_lap);
        nxt = m_state;
        case (m_state)
            0: if (ss) nxt = 1;
            1: if (ss) nxt = 2;
            default: if (clr) nxt = 0; else if (ss) nxt = 1;
        endcase
        m_wrap = 1'b0;
        if (m_state == 1) begin
            m_run_clks++;
            if (m_run_clks % (TD * 6000) == 0) m_wrap = 1'b1;
        end
        if (nxt == 0) m_run_clks = 0;
`ifdef STOPWATCH_LAP_EN
        if (m_state == 1 && lap) begin
            m_hold = !m_hold;
            if (m_hold) m_cap = live_cs();
        end
        if (nxt == 0) m_hold = 1'b0;
`else
        if (lap) m_hold = 1'b0;
`endif
        m_state = nxt;
    endtask

    task automatic check_all(input string tag);
        int cs;
        cs = m_hold ? m_cap : live_cs();
        chk({tag, ".dig0"}, 32'(dig0), 32'(cs / 1000));
        chk({tag, ".dig1"}, 32'(dig1), 32'((cs / 100) % 10));
        chk({tag, ".dig2"}, 32'(dig2), 32'((cs / 10) % 10));
        chk({tag, ".dig3"}, 32'(dig3), 32'(cs % 10));
        chk({tag, ".running"}, 32'(running), 32'(m_state == 1));
        chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
        chk({tag, ".lap_held"}, 32'(lap_held), 32'(m_hold));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (sys_rst_n) model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic run_until(input int target, input string tag);
        int k = 0;
        while (m_run_clks != target && k < 5000) begin
            step(tag);
            k++;
        end
        chk({tag, ".reached"}, 32'(k < 5000), 32'd1);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        btn_start_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();
        chk("reset.digits", {16'd0, dig0, dig1, dig2, dig3}, 32'h0000);

        // clean start press: running at raw edge + DB+2, then 1000 clks = 01.00
        btn_start_stop = 1'b1;
        run(5, "t2_pre");
        chk("t2.not_yet", 32'(running), 32'd0);
        run(1, "t2_go");
        chk("t2.running", 32'(running), 32'd1);
        run(20, "t2_run");
        btn_start_stop = 1'b0;
        run(980, "t2_run");
        chk("t2.digits", {16'd0, dig0, dig1, dig2, dig3}, 32'h0100);

        // reset in the middle of a run at 00.37
        do_reset();
        btn_start_stop = 1'b1; run(10, "t1_start"); btn_start_stop = 1'b0;
        run_until(370, "t1_run");
        chk("t1.at37", {16'd0, dig0, dig1, dig2, dig3}, 32'h0037);
        do_reset();
        chk("t1.digits", {16'd0, dig0, dig1, dig2, dig3}, 32'h0000);
        chk("t1.running", 32'(running), 32'd0);
        run(50, "t1_idle");

        // short glitches never qualify
        for (int i = 0; i < 6; i++) begin
            btn_start_stop = ~btn_start_stop;
            run(2, "t3_glitch");
        end
        btn_start_stop = 1'b0;
        run(30, "t3_after");
        chk("t3.running", 32'(running), 32'd0);
        chk("t3.digits", {16'd0, dig0, dig1, dig2, dig3}, 32'h0000);

        // full minute rollover
        do_reset();
        btn_start_stop = 1'b1;
        run(6, "t4_start");
        run(20, "t4_run");
        btn_start_stop = 1'b0;
        run(59979, "t4_run");
        chk("t4.at5999", {16'd0, dig0, dig1, dig2, dig3}, 32'h5999);
        chk("t4.wrap_pre", 32'(wrap), 32'd0);
        run(1, "t4_wrap");
        chk("t4.zero", {16'd0, dig0, dig1, dig2, dig3}, 32'h0000);
        chk("t4.wrap", 32'(wrap), 32'd1);
        chk("t4.running", 32'(running), 32'd1);
        run(1, "t4_post");
        chk("t4.wrap_post", 32'(wrap), 32'd0);

        // pause, clear, simultaneous presses
        do_reset();
        btn_start_stop = 1'b1; run(10, "t5_start"); btn_start_stop = 1'b0; run(10, "t5_run");
        btn_clear = 1'b1; run(10, "t5_clr_run"); btn_clear = 1'b0; run(10, "t5_run");
        chk("t5.clr_ignored", 32'(running), 32'd1);
        run_until(365, "t5_run");
        btn_start_stop = 1'b1;
        run(6, "t5_pause");
        chk("t5.paused", 32'(running), 32'd0);
        chk("t5.pause37", {16'd0, dig0, dig1, dig2, dig3}, 32'h0037);
        run(10, "t5_pause"); btn_start_stop = 1'b0; run(20, "t5_pause");
        chk("t5.hold37", {16'd0, dig0, dig1, dig2, dig3}, 32'h0037);
        btn_clear = 1'b1;
        run(6, "t5_clear");
        chk("t5.cleared", {16'd0, dig0, dig1, dig2, dig3}, 32'h0000);
        run(4, "t5_clear"); btn_clear = 1'b0; run(20, "t5_idle");
        btn_start_stop = 1'b1; btn_clear = 1'b1;
        run(6, "t5_both_idle");
        chk("t5.both_idle", 32'(running), 32'd1);
        run(4, "t5_run"); btn_start_stop = 1'b0; btn_clear = 1'b0; run(20, "t5_run");
        btn_start_stop = 1'b1; btn_clear = 1'b1;
        run(6, "t5_both_run");
        chk("t5.both_run", 32'(running), 32'd0);
        run(4, "t5_pause"); btn_start_stop = 1'b0; btn_clear = 1'b0; run(20, "t5_pause");
        btn_start_stop = 1'b1; btn_clear = 1'b1;
        run(6, "t5_both_pause");
        chk("t5.both_pause_run", 32'(running), 32'd0);
        chk("t5.both_pause_dig", {16'd0, dig0, dig1, dig2, dig3}, 32'h0000);
        run(4, "t5_idle"); btn_start_stop = 1'b0; btn_clear = 1'b0; run(20, "t5_idle");

        // lap hold
        do_reset();
        btn_start_stop = 1'b1; run(10, "t6_start"); btn_start_stop = 1'b0;
        run_until(495, "t6_run");
        btn_lap = 1'b1; run(10, "t6_lap"); btn_lap = 1'b0; run(190, "t6_held");
`ifdef STOPWATCH_LAP_EN
        chk("t6.held_dig", {16'd0, dig0, dig1, dig2, dig3}, 32'h0050);
        chk("t6.held", 32'(lap_held), 32'd1);
        btn_lap = 1'b1;
        run(6, "t6_release");
        chk("t6.released_dig", {16'd0, dig0, dig1, dig2, dig3}, 32'h0070);
        chk("t6.released", 32'(lap_held), 32'd0);
        run(4, "t6_release"); btn_lap = 1'b0; run(20, "t6_run");
`else
        chk("t6.no_lap", 32'(lap_held), 32'd0);
        chk("t6.live_dig", {16'd0, dig0, dig1, dig2, dig3}, 32'h0069);
`endif

        // random button traffic, including bounces
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) btn_start_stop = ~btn_start_stop;
            if ($urandom_range(0, 59) == 0) btn_clear = ~btn_clear;
            if ($urandom_range(0, 49) == 0) btn_lap = ~btn_lap;
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
